// File: rtl/aes_block_loader_if.sv
// ---------------------------------------------------------------------------
// aes_block_loader_if
// Bundles the byte stream, control strobes and AES-facing outputs of the
// byte-serial AES block loader.
//   byte_in/byte_valid/byte_ready : 8-bit valid/ready byte stream
//   key_reload, flush             : single-cycle control requests
//   Key_out, In_out, start        : assembled key/block and start strobe
//   key_loaded, busy, state       : status
// The master modport is the byte source/consumer side; slave is the loader.
// ---------------------------------------------------------------------------
interface aes_block_loader_if;
   logic [7:0]   byte_in;
   logic         byte_valid;
   logic         byte_ready;
   logic         key_reload;
   logic         flush;
   logic [127:0] Key_out;
   logic [127:0] In_out;
   logic         start;
   logic         key_loaded;
   logic         busy;
   logic [1:0]   state;

   modport master (
      output byte_in, byte_valid, key_reload, flush,
      input  byte_ready, Key_out, In_out, start, key_loaded, busy, state
   );

   modport slave (
      input  byte_in, byte_valid, key_reload, flush,
      output byte_ready, Key_out, In_out, start, key_loaded, busy, state
   );
endinterface

// File: rtl/aes_block_loader.sv
// ---------------------------------------------------------------------------
// aes_block_loader
// Assembles a 128-bit AES key and a 128-bit plaintext block from an MSB-first
// byte stream, presents them atomically to the AES top level with a one-cycle
// start pulse, then holds them stable for HOLD_CYCLES cycles.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : aes_block_loader_if.slave (byte stream, controls, outputs)
// ---------------------------------------------------------------------------
module aes_block_loader #(
   parameter int BYTES       = 16,
   parameter int HOLD_CYCLES = 23
) (
   input  logic               clk,
   input  logic               rst,
   aes_block_loader_if.slave  bus
);

   localparam int         SW        = 8 * BYTES;
   localparam int         HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [3:0] CNT_LAST  = 4'(BYTES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_LOAD_KEY  = 2'b00,
      ST_LOAD_DATA = 2'b01,
      ST_HOLD      = 2'b10
   } state_t;

   state_t         r_state,        w_state_nxt;
   logic [3:0]     r_byte_cnt,     w_byte_cnt_nxt;
   logic [SW-1:0]  r_staging,      w_staging_nxt;
   logic [SW-1:0]  r_key,          w_key_nxt;
   logic [SW-1:0]  r_in,           w_in_nxt;
   logic           r_start,        w_start_nxt;
   logic           r_key_loaded,   w_key_loaded_nxt;
   logic           r_busy,         w_busy_nxt;
   logic [HW-1:0]  r_hold_cnt,     w_hold_cnt_nxt;
   logic           r_pending,      w_pending_nxt;

   logic           w_byte_ready;
   logic           w_accept;
   logic           w_last_byte;
   logic [SW-1:0]  w_shifted;

   assign w_byte_ready = (r_state != ST_HOLD);
   assign w_accept     = bus.byte_valid && w_byte_ready;
   assign w_last_byte  = (r_byte_cnt == CNT_LAST);
   // First byte ends up in the top byte: MSB-first, FIPS-197 order.
   assign w_shifted    = {r_staging[SW-9:0], bus.byte_in};

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_byte_cnt_nxt   = r_byte_cnt;
      w_staging_nxt    = r_staging;
      w_key_nxt        = r_key;
      w_in_nxt         = r_in;
      w_start_nxt      = 1'b0;
      w_key_loaded_nxt = r_key_loaded;
      w_busy_nxt       = r_busy;
      w_hold_cnt_nxt   = r_hold_cnt;
      w_pending_nxt    = r_pending | bus.key_reload;

      unique case (r_state)
         ST_LOAD_KEY: begin
            // A reload request while already loading a key is redundant.
            w_pending_nxt = 1'b0;
            if (bus.flush) begin
               w_byte_cnt_nxt = '0;
               w_staging_nxt  = '0;
            end else if (w_accept) begin
               w_byte_cnt_nxt = r_byte_cnt + 4'd1;
               w_staging_nxt  = w_shifted;
               if (w_last_byte) begin
                  w_key_nxt        = w_shifted;
                  w_key_loaded_nxt = 1'b1;
                  w_state_nxt      = ST_LOAD_DATA;
               end
            end
         end

         ST_LOAD_DATA: begin
            if (bus.flush) begin
               w_byte_cnt_nxt = '0;
               w_staging_nxt  = '0;
            end else if (w_accept) begin
               w_byte_cnt_nxt = r_byte_cnt + 4'd1;
               w_staging_nxt  = w_shifted;
               if (w_last_byte) begin
                  w_in_nxt       = w_shifted;
                  w_state_nxt    = ST_HOLD;
                  w_start_nxt    = 1'b1;
                  w_busy_nxt     = 1'b1;
                  w_hold_cnt_nxt = '0;
               end
            end
            // Between blocks a reload can act at once; mid-block it waits
            // for the block and its hold window to finish.
            if (bus.key_reload && (r_byte_cnt == 4'd0)) begin
               w_state_nxt   = ST_LOAD_KEY;
               w_pending_nxt = 1'b0;
            end
         end

         ST_HOLD: begin
            // flush is ignored here; bytes are refused via byte_ready.
            w_hold_cnt_nxt = r_hold_cnt + HW'(1);
            if (r_hold_cnt == HOLD_LAST) begin
               w_busy_nxt = 1'b0;
               if (w_pending_nxt) begin
                  w_state_nxt   = ST_LOAD_KEY;
                  w_pending_nxt = 1'b0;
               end else begin
                  w_state_nxt = ST_LOAD_DATA;
               end
            end
         end

         default: begin
            w_state_nxt = ST_LOAD_KEY;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_LOAD_KEY;
         r_byte_cnt   <= '0;
         r_staging    <= '0;
         r_key        <= '0;
         r_in         <= '0;
         r_start      <= 1'b0;
         r_key_loaded <= 1'b0;
         r_busy       <= 1'b0;
         r_hold_cnt   <= '0;
         r_pending    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_byte_cnt   <= w_byte_cnt_nxt;
         r_staging    <= w_staging_nxt;
         r_key        <= w_key_nxt;
         r_in         <= w_in_nxt;
         r_start      <= w_start_nxt;
         r_key_loaded <= w_key_loaded_nxt;
         r_busy       <= w_busy_nxt;
         r_hold_cnt   <= w_hold_cnt_nxt;
         r_pending    <= w_pending_nxt;
      end
   end

   assign bus.byte_ready = w_byte_ready;
   assign bus.Key_out    = r_key;
   assign bus.In_out     = r_in;
   assign bus.start      = r_start;
   assign bus.key_loaded = r_key_loaded;
   assign bus.busy       = r_busy;
   assign bus.state      = r_state;

endmodule

// File: tb/tb_aes_block_loader.sv
// ---------------------------------------------------------------------------
// tb_aes_block_loader
// Directed byte streams into aes_block_loader. Each completed block pushes
// its expected {key, block} pair; a monitor pops and compares on every start
// pulse and tracks the length of each hold window.
// ---------------------------------------------------------------------------
module tb_aes_block_loader;

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2  = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] B1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B2  = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] B3  = 128'h101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] B4  = 128'hffffffffffffffffffffffffffffffff;
   localparam logic [127:0] B5  = 128'h202122232425262728292a2b2c2d2e2f;
   localparam int           HOLD = 23;

   typedef struct {
      logic [127:0] key;
      logic [127:0] blk;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   aes_block_loader_if bus ();

   aes_block_loader #(
      .BYTES       (16),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_block(input logic [127:0] k, input logic [127:0] b);
      exp_t e;
      e.key = k;
      e.blk = b;
      sb.push_back(e);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.byte_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.byte_ready) check("ready_timeout", 128'(bus.byte_ready), 128'd1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      wait_ready();
      bus.byte_valid = 1'b1;
      bus.byte_in    = b;
      @(negedge clk);
      bus.byte_valid = 1'b0;
   endtask

   // Sends bytes lo..hi of v, MSB-first; optional idle cycle between bytes.
   task automatic send_range(input logic [127:0] v, input int lo, input int hi, input bit gapped);
      for (int i = lo; i <= hi; i++) begin
         send_byte(v[127-8*i -: 8]);
         if (gapped && i < hi) @(negedge clk);
      end
   endtask

   // Scoreboard monitor: compare outputs on each start, check pulse width,
   // measure hold windows and busy/byte_ready consistency.
   logic prev_start = 1'b0;
   int   hold_run   = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.start) begin
            check("start_width", 128'(prev_start), 128'd0);
            if (sb.size() == 0) begin
               check("unexpected_start", 128'(bus.start), 128'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("key_at_start", bus.Key_out, e.key);
               check("in_at_start", bus.In_out, e.blk);
            end
         end
         check("busy_vs_ready", 128'(bus.busy), 128'(!bus.byte_ready));
         if (!bus.byte_ready) begin
            hold_run++;
         end else if (hold_run != 0) begin
            check("hold_length", 128'(hold_run), 128'(HOLD));
            hold_run = 0;
         end
      end
      prev_start = bus.start;
   end

   initial begin
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      bus.key_reload = 1'b0;
      bus.flush      = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_key", bus.Key_out, 128'd0);
      check("rst_in", bus.In_out, 128'd0);
      check("rst_state", 128'(bus.state), 128'd0);
      check("rst_key_loaded", 128'(bus.key_loaded), 128'd0);
      check("rst_busy", 128'(bus.busy), 128'd0);
      check("rst_start", 128'(bus.start), 128'd0);
      check("rst_ready", 128'(bus.byte_ready), 128'd1);
      rst = 1'b0;
      @(negedge clk);

      // Key load, contiguous valid
      send_range(K1, 0, 15, 1'b0);
      check("key1", bus.Key_out, K1);
      check("key1_loaded", 128'(bus.key_loaded), 128'd1);
      check("key1_state", 128'(bus.state), 128'd1);
      check("key1_in_untouched", bus.In_out, 128'd0);

      // First block: start one cycle after the 16th byte edge
      expect_block(K1, B1);
      send_range(B1, 0, 15, 1'b0);
      check("b1_start_latency", 128'(bus.start), 128'd1);
      check("b1_state_hold", 128'(bus.state), 128'd2);
      check("b1_ready_low", 128'(bus.byte_ready), 128'd0);
      @(negedge clk);
      check("b1_start_pulse", 128'(bus.start), 128'd0);
      wait_ready();

      // Gapped valid; In_out must not move before the 16th byte
      expect_block(K1, B2);
      send_range(B2, 0, 14, 1'b1);
      check("b2_atomic", bus.In_out, B1);
      @(negedge clk);
      send_range(B2, 15, 15, 1'b0);
      check("b2_start", 128'(bus.start), 128'd1);

      // Bytes offered throughout the hold window must be refused
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'haa;
      repeat (HOLD) @(negedge clk);
      check("hold_exit_ready", 128'(bus.byte_ready), 128'd1);
      bus.byte_valid = 1'b0;

      // A refused byte would complete this block one byte early
      expect_block(K1, B3);
      send_range(B3, 0, 14, 1'b0);
      check("b3_after_hold", bus.In_out, B2);
      send_range(B3, 15, 15, 1'b0);
      wait_ready();

      // Partial block, flush (with a byte offered the same cycle), full block
      for (int i = 0; i < 7; i++) send_byte(8'h33);
      bus.flush      = 1'b1;
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'h77;
      @(negedge clk);
      bus.flush      = 1'b0;
      bus.byte_valid = 1'b0;
      expect_block(K1, B4);
      for (int i = 0; i < 15; i++) send_byte(8'hff);
      check("flush_count", bus.In_out, B3);
      check("flush_key_kept", bus.Key_out, K1);
      send_byte(8'hff);
      wait_ready();

      // key_reload mid-block waits for block completion and full hold
      expect_block(K1, B5);
      send_range(B5, 0, 4, 1'b0);
      bus.key_reload = 1'b1;
      @(negedge clk);
      bus.key_reload = 1'b0;
      send_range(B5, 5, 15, 1'b0);
      check("reload_block_done", 128'(bus.state), 128'd2);
      wait_ready();
      check("reload_to_key", 128'(bus.state), 128'd0);
      check("reload_key_loaded", 128'(bus.key_loaded), 128'd1);
      send_range(K2, 0, 15, 1'b0);
      check("key2", bus.Key_out, K2);
      check("key2_state", 128'(bus.state), 128'd1);

      expect_block(K2, B1);
      send_range(B1, 0, 15, 1'b0);
      wait_ready();
      check("b6_back_to_data", 128'(bus.state), 128'd1);

      // key_reload between blocks acts on the next cycle
      bus.key_reload = 1'b1;
      @(negedge clk);
      bus.key_reload = 1'b0;
      check("reload_idle", 128'(bus.state), 128'd0);
      check("reload_idle_key", bus.Key_out, K2);

      // Asynchronous reset in the middle of a key load
      send_range(K1, 0, 7, 1'b0);
      #1 rst = 1'b1;
      #1;
      check("arst_key", bus.Key_out, 128'd0);
      check("arst_in", bus.In_out, 128'd0);
      check("arst_state", 128'(bus.state), 128'd0);
      check("arst_key_loaded", 128'(bus.key_loaded), 128'd0);
      check("arst_busy", 128'(bus.busy), 128'd0);
      check("arst_start", 128'(bus.start), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("scoreboard_drained", 128'(sb.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
